// File: rtl/keypad_event_gen.sv
// Debounces a 12-key pad and turns clean single-key presses into key-index events.
// Latency: event valid DEBOUNCE_CYCLES+3 edges after the first edge sampling a clean press.
// Backpressure: one-entry output buffer; events arriving while it is full are dropped and flagged in overflow.
module keypad_event_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_raw,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic [11:0] keys_db,
    output logic        overflow,
    output logic        multi_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ONE,
        MULTI
    } state_t;

    logic [11:0]      sync1;
    logic [11:0]      sync2;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    logic             any_key;
    logic             single_key;
    logic [3:0]       key_idx;
    logic             new_evt;

    // sync1 holds the value sync2 takes next, so a mismatch clears the
    // counter on the very edge the synchronized vector changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            cnt     <= '0;
            keys_db <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (sync1 != sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_MAX - CNT_W'(1)) begin
                    keys_db <= sync2;
                end
            end
        end
    end

    always_comb begin
        any_key    = |keys_db;
        single_key = any_key && ((keys_db & (keys_db - 12'd1)) == 12'd0);
        key_idx    = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (keys_db[i]) begin
                key_idx = 4'(i);
            end
        end
        new_evt = (state == IDLE) && single_key;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_code  <= 4'd0;
            overflow  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            multi_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (single_key) begin
                        state <= ONE;
                    end else if (any_key) begin
                        state     <= MULTI;
                        multi_err <= 1'b1;
                    end
                end
                ONE: begin
                    if (!any_key) begin
                        state <= IDLE;
                    end else if (!single_key) begin
                        state <= MULTI;
                    end
                end
                MULTI: begin
                    if (!any_key) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A full buffer that is being accepted this edge can take the new event.
            if (new_evt) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= key_idx;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_event_gen.sv
// Directed bench for keypad_event_gen with a short debounce window.
module tb_keypad_event_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] key_raw;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic [11:0] keys_db;
    logic        overflow;
    logic        multi_err;

    int errors = 0;
    int checks = 0;

    keypad_event_gen #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_raw),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .keys_db  (keys_db),
        .overflow (overflow),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] key;
        logic        exp_evt;
        logic [3:0]  exp_code;
        logic        exp_multi;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int evts;
        int multis;
        int bad;
        int code3;
        bit got;

        vecs[0] = '{key: 12'h080, exp_evt: 1'b1, exp_code: 4'd7,  exp_multi: 1'b0};
        vecs[1] = '{key: 12'h001, exp_evt: 1'b1, exp_code: 4'd0,  exp_multi: 1'b0};
        vecs[2] = '{key: 12'h800, exp_evt: 1'b1, exp_code: 4'd11, exp_multi: 1'b0};
        vecs[3] = '{key: 12'h024, exp_evt: 1'b0, exp_code: 4'd0,  exp_multi: 1'b1};
        vecs[4] = '{key: 12'h400, exp_evt: 1'b1, exp_code: 4'd10, exp_multi: 1'b0};

        rst       = 1'b1;
        key_raw   = '0;
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_keys_db", 32'(keys_db), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_multi_err", 32'(multi_err), 0);
        chk("rst_code", 32'(evt_code), 0);
        rst = 1'b0;
        cycles(10);

        // Table: press each pattern, check exact latency, hold, release.
        for (int v = 0; v < 5; v++) begin
            key_raw = vecs[v].key;
            cycles(5);
            chk("keys_db_not_early", 32'(keys_db), 0);
            cycles(1);
            chk("keys_db_loaded", 32'(keys_db), 32'(vecs[v].key));
            chk("no_early_evt", 32'(evt_valid), 0);
            cycles(1);
            chk("evt_valid_at_7", 32'(evt_valid), 32'(vecs[v].exp_evt));
            if (vecs[v].exp_evt) chk("evt_code", 32'(evt_code), 32'(vecs[v].exp_code));
            chk("multi_err_at_7", 32'(multi_err), 32'(vecs[v].exp_multi));
            cycles(1);
            chk("evt_one_cycle", 32'(evt_valid), 0);
            chk("multi_err_pulse", 32'(multi_err), 0);
            evts   = 0;
            multis = 0;
            for (int c = 0; c < 100; c++) begin
                cycles(1);
                if (evt_valid) evts++;
                if (multi_err) multis++;
            end
            chk("hold_no_repeat", 32'(evts), 0);
            chk("hold_no_multi", 32'(multis), 0);
            key_raw = '0;
            cycles(20);
            chk("released", 32'(keys_db), 0);
        end

        // Bit 3 bouncing, then stable.
        bad   = 0;
        code3 = 0;
        evts  = 0;
        for (int c = 0; c < 40; c++) begin
            key_raw = (c < 10 && ((c / 2) % 2) == 1) ? 12'h000 : 12'h008;
            cycles(1);
            if (keys_db != 12'h000 && keys_db != 12'h008) bad++;
            if (evt_valid) begin
                evts++;
                if (evt_code == 4'd3) code3++;
            end
        end
        chk("bounce_no_intermediate", 32'(bad), 0);
        chk("bounce_one_event", 32'(evts), 1);
        chk("bounce_code3", 32'(code3), 1);
        chk("bounce_keys_db", 32'(keys_db), 32'h008);
        key_raw = '0;
        cycles(20);

        // ONE -> MULTI: extra key gives no event and no multi_err.
        key_raw = 12'h002;
        evts = 0;
        for (int c = 0; c < 10; c++) begin
            cycles(1);
            if (evt_valid) evts++;
        end
        chk("one_first_evt", 32'(evts), 1);
        key_raw = 12'h006;
        evts   = 0;
        multis = 0;
        for (int c = 0; c < 20; c++) begin
            cycles(1);
            if (evt_valid) evts++;
            if (multi_err) multis++;
        end
        chk("one_to_multi_no_evt", 32'(evts), 0);
        chk("one_to_multi_no_err", 32'(multis), 0);
        chk("one_to_multi_db", 32'(keys_db), 32'h006);
        key_raw = '0;
        cycles(20);

        // Overflow: buffered code 1 survives a dropped code 4.
        evt_ready = 1'b0;
        key_raw   = 12'h002;
        cycles(10);
        key_raw = '0;
        cycles(12);
        key_raw = 12'h010;
        cycles(12);
        chk("ovf_valid", 32'(evt_valid), 1);
        chk("ovf_code_kept", 32'(evt_code), 1);
        chk("ovf_flag", 32'(overflow), 1);
        evt_ready = 1'b1;
        cycles(1);
        chk("ovf_accepted", 32'(evt_valid), 0);
        evts = 0;
        for (int c = 0; c < 20; c++) begin
            cycles(1);
            if (evt_valid) evts++;
        end
        chk("ovf_no_code4", 32'(evts), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        key_raw = '0;
        cycles(20);

        // Reset with a buffered event, key held through reset.
        evt_ready = 1'b0;
        key_raw   = 12'h040;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            cycles(1);
            if (evt_valid) got = 1'b1;
        end
        chk("pre_rst_evt", 32'(got), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(evt_valid), 0);
        chk("rst_async_overflow", 32'(overflow), 0);
        chk("rst_async_keys_db", 32'(keys_db), 0);
        evt_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cycles(6);
        chk("post_rst_not_early", 32'(evt_valid), 0);
        cycles(1);
        chk("post_rst_evt", 32'(evt_valid), 1);
        chk("post_rst_code", 32'(evt_code), 6);
        evts = 0;
        for (int c = 0; c < 30; c++) begin
            cycles(1);
            if (evt_valid) evts++;
        end
        chk("post_rst_no_dup", 32'(evts), 0);
        key_raw = '0;
        cycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_event_gen.md
KEYPAD_EVENT_GEN -- requirements
Module: keypad_event_gen

Interface
REQ-001 Parameters SHALL be:
  - DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required (10 ms at 50 MHz).
  - CNT_W, default 20, width of the debounce counter.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, single clock.
  - rst, in, 1, asynchronous active-high reset.
  - key_raw, in, 12, bouncy asynchronous keys; bits 0-9 digits 0-9, bit 10 ENTER (advance field), bit 11 CLEAR.
  - evt_valid, out, 1, key event pending.
  - evt_ready, in, 1, downstream entry stage accepts the event.
  - evt_code, out, 4, key index 0-11, valid while evt_valid.
  - keys_db, out, 12, current debounced key vector.
  - overflow, out, 1, sticky: an event was lost.
  - multi_err, out, 1, pulse: a multi-key press was rejected.

Function
REQ-003 key_raw SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-004 Debounce counter:
  - cleared whenever the synchronized vector differs from its previous-cycle value, otherwise incremented;
  - saturates at DEBOUNCE_CYCLES;
  - on the edge it reaches DEBOUNCE_CYCLES, keys_db loads the synchronized vector.
REQ-005 Press FSM states SHALL be IDLE, ONE, MULTI.
REQ-006 IDLE -> ONE when keys_db becomes exactly one-hot; that key generates one event.
REQ-007 IDLE -> MULTI when keys_db has two or more bits set; no event is generated and multi_err pulses for one cycle.
REQ-008 ONE and MULTI SHALL return to IDLE only when keys_db is all-zero.
REQ-009 While in ONE or MULTI, any further key changes SHALL generate no event (no auto-repeat, no rollover).
REQ-010 ONE -> MULTI when keys_db gains an extra key; no extra event and no multi_err.
REQ-011 Event latency: an event SHALL raise evt_valid on the edge after keys_db updates, i.e. DEBOUNCE_CYCLES+3 edges after the first edge sampling a clean press.
REQ-012 evt_code SHALL be the index of the single set bit of keys_db.
REQ-013 Output buffer (one entry):
  - evt_valid and evt_code are held stable until evt_valid and evt_ready are both high on an edge;
  - evt_valid deasserts on the edge following acceptance, unless a new event loads on that same edge.
REQ-014 New event while the buffer is full and not accepted that edge: the new event SHALL be dropped, the old one kept, and overflow set to 1.
REQ-015 New event on the same edge the buffered one is accepted: the new event SHALL load and evt_valid stays 1.
REQ-016 overflow SHALL clear only on rst; CLEAR key events are ordinary events with code 11 and do not clear it.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES SHALL never change keys_db.
REQ-018 evt_ready SHALL be ignored while evt_valid is 0.

Reset
REQ-019 rst SHALL act immediately, independent of clk, and SHALL set:
  - synchronizers, counter, keys_db: 0;
  - FSM: IDLE;
  - evt_valid, evt_code, overflow, multi_err: 0.
REQ-020 A pending event SHALL be discarded on rst.
REQ-021 A key held through rst deassertion SHALL be debounced afresh and generate one event.
REQ-022 rst asserted mid-debounce or mid-handshake SHALL yield no partial or duplicate event.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 Clean press of bit 7, evt_ready=1:
  - evt_valid=1 with evt_code=7 exactly 7 edges after the first sampling edge, for one cycle;
  - holding the key 100 cycles produces no further event.
REQ-024 Bit 3 bouncing (toggled every 2 cycles for 10 cycles) then stable: exactly one event with code 3, and keys_db shows no intermediate values.
REQ-025 Bits 2 and 5 pressed together: multi_err pulses once and no event is generated; releasing, then pressing bit 10 alone, yields evt_code=10.
REQ-026 evt_ready=0, press 1 (release), then press 4: evt_code stays 1, overflow=1. Raising evt_ready then accepts code 1 and no code-4 event appears.
REQ-027 Buffered event with evt_ready=0, rst pulsed between edges: evt_valid=0 and overflow=0 immediately. A key held through rst yields exactly one event after rst release plus 7 edges.
